// File: rtl/v_rf_wr_sched_if.sv
// Request and register-file write bundle for the vector RF write-port scheduler.
// The scheduler uses the slave modport; requesters and the register file sit on the master side.
interface v_rf_wr_sched_if #(parameter int NREG = 32);
  logic            stall;

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_addr;
  logic [2:0]      alu_lmul;
  logic [127:0]    alu_data0, alu_data1, alu_data2, alu_data3;

  logic            lsg_valid;
  logic            lsg_ready;
  logic [4:0]      lsg_addr;
  logic [2:0]      lsg_lmul;
  logic [127:0]    lsg_data0, lsg_data1, lsg_data2, lsg_data3;

  logic            lse_valid;
  logic            lse_ready;
  logic [4:0]      lse_reg;
  logic [4:0]      lse_idx;
  logic [2:0]      lse_sew;
  logic [127:0]    lse_data;

  logic            reg_wr_en;
  logic [4:0]      reg_wr_addr;
  logic [127:0]    reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4;
  logic            el_wr_en;
  logic [4:0]      el_reg_wr_addr;
  logic [4:0]      el_wr_addr;
  logic [127:0]    el_wr_data;
  logic [2:0]      lmul;
  logic [2:0]      sew;
  logic [NREG-1:0] wr_mask;
  logic            err;
  logic [1:0]      err_src;

  modport slave (
    input  stall,
    input  alu_valid, alu_addr, alu_lmul, alu_data0, alu_data1, alu_data2, alu_data3,
    output alu_ready,
    input  lsg_valid, lsg_addr, lsg_lmul, lsg_data0, lsg_data1, lsg_data2, lsg_data3,
    output lsg_ready,
    input  lse_valid, lse_reg, lse_idx, lse_sew, lse_data,
    output lse_ready,
    output reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
    output el_wr_en, el_reg_wr_addr, el_wr_addr, el_wr_data,
    output lmul, sew, wr_mask, err, err_src
  );

  modport master (
    output stall,
    output alu_valid, alu_addr, alu_lmul, alu_data0, alu_data1, alu_data2, alu_data3,
    input  alu_ready,
    output lsg_valid, lsg_addr, lsg_lmul, lsg_data0, lsg_data1, lsg_data2, lsg_data3,
    input  lsg_ready,
    output lse_valid, lse_reg, lse_idx, lse_sew, lse_data,
    input  lse_ready,
    input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
    input  el_wr_en, el_reg_wr_addr, el_wr_addr, el_wr_data,
    input  lmul, sew, wr_mask, err, err_src
  );
endinterface

// File: rtl/v_rf_wr_sched.sv
// Round-robin write-port scheduler for the vector register file: ALU group, load group and
// load element requesters share one registered write stage with legality checking.
module v_rf_wr_sched #(
  parameter int NREG = 32
) (
  input logic            clk,
  input logic            rst,
  v_rf_wr_sched_if.slave bus
);

  logic [1:0]      rr;
  logic [2:0]      vld;
  logic [2:0]      gnt;
  logic            gnt_any;
  logic [1:0]      win;
  int              cand;

  logic [4:0]      grp_addr;
  logic [2:0]      grp_lmul;
  logic [3:0]      grp_n;
  logic [NREG-1:0] grp_ones;
  logic [NREG-1:0] grp_mask;
  logic            grp_ok;
  logic            el_ok;

  // rr names the requester scanned first; the scan wraps modulo 3
  always_comb begin
    vld     = {bus.lse_valid, bus.lsg_valid, bus.alu_valid};
    gnt_any = 1'b0;
    win     = 2'd0;
    cand    = 0;
    for (int k = 0; k < 3; k++) begin
      cand = (int'(rr) + k) % 3;
      if (!gnt_any && vld[cand]) begin
        gnt_any = 1'b1;
        win     = 2'(cand);
      end
    end
    if (bus.stall || rst) gnt_any = 1'b0;
    gnt = gnt_any ? (3'b001 << win) : 3'b000;
  end

  assign bus.alu_ready = gnt[0];
  assign bus.lsg_ready = gnt[1];
  assign bus.lse_ready = gnt[2];

  always_comb begin
    grp_addr = (win == 2'd1) ? bus.lsg_addr : bus.alu_addr;
    grp_lmul = (win == 2'd1) ? bus.lsg_lmul : bus.alu_lmul;
    case (grp_lmul)
      3'd0:    begin grp_n = 4'd1; grp_ones = NREG'(1);  end
      3'd1:    begin grp_n = 4'd2; grp_ones = NREG'(3);  end
      3'd2:    begin grp_n = 4'd4; grp_ones = NREG'(15); end
      default: begin grp_n = 4'd0; grp_ones = '0;        end
    endcase
    grp_mask = grp_ones << grp_addr;
    grp_ok   = (grp_n != 4'd0)
            && ((grp_addr & (5'(grp_n) - 5'd1)) == 5'd0)
            && (int'(grp_addr) + int'(grp_n) - 1 <= NREG - 1);
    case (bus.lse_sew)
      3'd0:    el_ok = (bus.lse_idx < 5'd16);
      3'd1:    el_ok = (bus.lse_idx < 5'd8);
      3'd2:    el_ok = (bus.lse_idx < 5'd4);
      default: el_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr                 <= 2'd0;
      bus.reg_wr_en      <= 1'b0;
      bus.reg_wr_addr    <= '0;
      bus.reg_wr_data    <= '0;
      bus.reg_wr_data_2  <= '0;
      bus.reg_wr_data_3  <= '0;
      bus.reg_wr_data_4  <= '0;
      bus.el_wr_en       <= 1'b0;
      bus.el_reg_wr_addr <= '0;
      bus.el_wr_addr     <= '0;
      bus.el_wr_data     <= '0;
      bus.lmul           <= 3'd0;
      bus.sew            <= 3'd0;
      bus.wr_mask        <= '0;
      bus.err            <= 1'b0;
      bus.err_src        <= 2'd0;
    end else begin
      bus.reg_wr_en <= 1'b0;
      bus.el_wr_en  <= 1'b0;
      bus.wr_mask   <= '0;
      bus.err       <= 1'b0;
      if (gnt_any) begin
        rr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
        if (win == 2'd2) begin
          if (el_ok) begin
            bus.el_wr_en       <= 1'b1;
            bus.el_reg_wr_addr <= bus.lse_reg;
            bus.el_wr_addr     <= bus.lse_idx;
            bus.el_wr_data     <= bus.lse_data;
            bus.sew            <= bus.lse_sew;
            bus.wr_mask        <= NREG'(1) << bus.lse_reg;
          end else begin
            bus.err     <= 1'b1;
            bus.err_src <= 2'd2;
          end
        end else if (grp_ok) begin
          bus.reg_wr_en     <= 1'b1;
          bus.reg_wr_addr   <= grp_addr;
          bus.reg_wr_data   <= (win == 2'd1) ? bus.lsg_data0 : bus.alu_data0;
          bus.reg_wr_data_2 <= (win == 2'd1) ? bus.lsg_data1 : bus.alu_data1;
          bus.reg_wr_data_3 <= (win == 2'd1) ? bus.lsg_data2 : bus.alu_data2;
          bus.reg_wr_data_4 <= (win == 2'd1) ? bus.lsg_data3 : bus.alu_data3;
          bus.lmul          <= grp_lmul;
          bus.wr_mask       <= grp_mask;
        end else begin
          bus.err     <= 1'b1;
          bus.err_src <= win;
        end
      end
    end
  end

endmodule

// File: tb/tb_v_rf_wr_sched.sv
// Directed bench for the RF write scheduler: a vector table walked in order from reset,
// followed by stall, reset-during-request and round-robin sequences.
module tb_v_rf_wr_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  v_rf_wr_sched_if #(.NREG(32)) bus();
  v_rf_wr_sched #(.NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam logic [127:0] A0 = {16{8'hA0}}, A1 = {16{8'hA1}}, A2 = {16{8'hA2}}, A3 = {16{8'hA3}};
  localparam logic [127:0] G0 = {16{8'hB0}}, G1 = {16{8'hB1}}, G2 = {16{8'hB2}}, G3 = {16{8'hB3}};
  localparam logic [127:0] E  = {16{8'hE5}};
  localparam logic [127:0] Z  = '0;

  typedef struct {
    logic st;
    logic av; logic [4:0] aa; logic [2:0] al;
    logic gv; logic [4:0] ga; logic [2:0] gl;
    logic ev; logic [4:0] er; logic [4:0] ei; logic [2:0] es;
    logic [2:0] rdy; logic ren; logic een;
    logic [4:0] ra; logic [4:0] xr; logic [4:0] xi;
    logic [2:0] lm; logic [2:0] sw; logic [31:0] mask;
    logic err; logic [1:0] esrc; logic [1:0] rr;
    logic [127:0] d0; logic [127:0] d3; logic [127:0] ed;
  } vec_t;

  vec_t vq[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall     = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_lmul = '0;
    bus.lsg_valid = 1'b0; bus.lsg_addr = '0; bus.lsg_lmul = '0;
    bus.lse_valid = 1'b0; bus.lse_reg = '0; bus.lse_idx = '0; bus.lse_sew = '0;
  endtask

  task automatic apply(input vec_t t, input int i);
    bus.stall     = t.st;
    bus.alu_valid = t.av; bus.alu_addr = t.aa; bus.alu_lmul = t.al;
    bus.lsg_valid = t.gv; bus.lsg_addr = t.ga; bus.lsg_lmul = t.gl;
    bus.lse_valid = t.ev; bus.lse_reg  = t.er; bus.lse_idx  = t.ei; bus.lse_sew = t.es;
    #1;
    chk($sformatf("v%0d ready", i), 128'({bus.lse_ready, bus.lsg_ready, bus.alu_ready}), 128'(t.rdy));
    @(posedge clk); #1;
    chk($sformatf("v%0d reg_wr_en", i), 128'(bus.reg_wr_en), 128'(t.ren));
    chk($sformatf("v%0d el_wr_en", i), 128'(bus.el_wr_en), 128'(t.een));
    chk($sformatf("v%0d reg_wr_addr", i), 128'(bus.reg_wr_addr), 128'(t.ra));
    chk($sformatf("v%0d el_reg_wr_addr", i), 128'(bus.el_reg_wr_addr), 128'(t.xr));
    chk($sformatf("v%0d el_wr_addr", i), 128'(bus.el_wr_addr), 128'(t.xi));
    chk($sformatf("v%0d lmul", i), 128'(bus.lmul), 128'(t.lm));
    chk($sformatf("v%0d sew", i), 128'(bus.sew), 128'(t.sw));
    chk($sformatf("v%0d wr_mask", i), 128'(bus.wr_mask), 128'(t.mask));
    chk($sformatf("v%0d err", i), 128'(bus.err), 128'(t.err));
    chk($sformatf("v%0d err_src", i), 128'(bus.err_src), 128'(t.esrc));
    chk($sformatf("v%0d rr", i), 128'(dut.rr), 128'(t.rr));
    chk($sformatf("v%0d reg_wr_data", i), bus.reg_wr_data, t.d0);
    chk($sformatf("v%0d reg_wr_data_4", i), bus.reg_wr_data_4, t.d3);
    chk($sformatf("v%0d el_wr_data", i), bus.el_wr_data, t.ed);
  endtask

  initial begin
    // st | alu v,addr,lmul | lsg v,addr,lmul | lse v,reg,idx,sew || rdy,ren,een,ra,xr,xi,lmul,sew,mask,err,esrc,rr,d0,d3,ed
    vq.push_back('{1'b0, 1'b1,5'd4,3'd2,  1'b0,5'd0,3'd0,  1'b0,5'd0,5'd0,3'd0,   3'b001,1'b1,1'b0,5'd4,5'd0,5'd0,3'd2,3'd0,32'h0000_00F0,1'b0,2'd0,2'd1, A0,A3,Z});
    vq.push_back('{1'b0, 1'b1,5'd0,3'd0,  1'b1,5'd8,3'd1,  1'b1,5'd3,5'd5,3'd1,   3'b010,1'b1,1'b0,5'd8,5'd0,5'd0,3'd1,3'd0,32'h0000_0300,1'b0,2'd0,2'd2, G0,G3,Z});
    vq.push_back('{1'b0, 1'b1,5'd0,3'd0,  1'b1,5'd8,3'd1,  1'b1,5'd3,5'd5,3'd1,   3'b100,1'b0,1'b1,5'd8,5'd3,5'd5,3'd1,3'd1,32'h0000_0008,1'b0,2'd0,2'd0, G0,G3,E});
    vq.push_back('{1'b0, 1'b1,5'd0,3'd0,  1'b1,5'd8,3'd1,  1'b1,5'd3,5'd5,3'd1,   3'b001,1'b1,1'b0,5'd0,5'd3,5'd5,3'd0,3'd1,32'h0000_0001,1'b0,2'd0,2'd1, A0,A3,E});
    vq.push_back('{1'b0, 1'b0,5'd0,3'd0,  1'b0,5'd0,3'd0,  1'b1,5'd3,5'd8,3'd1,   3'b100,1'b0,1'b0,5'd0,5'd3,5'd5,3'd0,3'd1,32'h0000_0000,1'b1,2'd2,2'd0, A0,A3,E});
    vq.push_back('{1'b0, 1'b1,5'd30,3'd2, 1'b0,5'd0,3'd0,  1'b0,5'd0,5'd0,3'd0,   3'b001,1'b0,1'b0,5'd0,5'd3,5'd5,3'd0,3'd1,32'h0000_0000,1'b1,2'd0,2'd1, A0,A3,E});
    vq.push_back('{1'b0, 1'b0,5'd0,3'd0,  1'b1,5'd5,3'd1,  1'b0,5'd0,5'd0,3'd0,   3'b010,1'b0,1'b0,5'd0,5'd3,5'd5,3'd0,3'd1,32'h0000_0000,1'b1,2'd1,2'd2, A0,A3,E});
    vq.push_back('{1'b0, 1'b1,5'd0,3'd3,  1'b0,5'd0,3'd0,  1'b0,5'd0,5'd0,3'd0,   3'b001,1'b0,1'b0,5'd0,5'd3,5'd5,3'd0,3'd1,32'h0000_0000,1'b1,2'd0,2'd1, A0,A3,E});
    vq.push_back('{1'b0, 1'b0,5'd0,3'd0,  1'b0,5'd0,3'd0,  1'b0,5'd0,5'd0,3'd0,   3'b000,1'b0,1'b0,5'd0,5'd3,5'd5,3'd0,3'd1,32'h0000_0000,1'b0,2'd0,2'd1, A0,A3,E});
    vq.push_back('{1'b0, 1'b0,5'd0,3'd0,  1'b1,5'd28,3'd2, 1'b0,5'd0,5'd0,3'd0,   3'b010,1'b1,1'b0,5'd28,5'd3,5'd5,3'd2,3'd1,32'hF000_0000,1'b0,2'd0,2'd2, G0,G3,E});
    vq.push_back('{1'b0, 1'b0,5'd0,3'd0,  1'b0,5'd0,3'd0,  1'b1,5'd31,5'd3,3'd2,  3'b100,1'b0,1'b1,5'd28,5'd31,5'd3,3'd2,3'd2,32'h8000_0000,1'b0,2'd0,2'd0, G0,G3,E});
    vq.push_back('{1'b0, 1'b0,5'd0,3'd0,  1'b0,5'd0,3'd0,  1'b1,5'd0,5'd0,3'd3,   3'b100,1'b0,1'b0,5'd28,5'd31,5'd3,3'd2,3'd2,32'h0000_0000,1'b1,2'd2,2'd0, G0,G3,E});
    vq.push_back('{1'b0, 1'b0,5'd0,3'd0,  1'b0,5'd0,3'd0,  1'b1,5'd0,5'd15,3'd0,  3'b100,1'b0,1'b1,5'd28,5'd0,5'd15,3'd2,3'd0,32'h0000_0001,1'b0,2'd2,2'd0, G0,G3,E});
    vq.push_back('{1'b0, 1'b1,5'd31,3'd0, 1'b0,5'd0,3'd0,  1'b0,5'd0,5'd0,3'd0,   3'b001,1'b1,1'b0,5'd31,5'd0,5'd15,3'd0,3'd0,32'h8000_0000,1'b0,2'd2,2'd1, A0,A3,E});
    vq.push_back('{1'b1, 1'b1,5'd0,3'd0,  1'b1,5'd0,3'd0,  1'b0,5'd0,5'd0,3'd0,   3'b000,1'b0,1'b0,5'd31,5'd0,5'd15,3'd0,3'd0,32'h0000_0000,1'b0,2'd2,2'd1, A0,A3,E});

    bus.alu_data0 = A0; bus.alu_data1 = A1; bus.alu_data2 = A2; bus.alu_data3 = A3;
    bus.lsg_data0 = G0; bus.lsg_data1 = G1; bus.lsg_data2 = G2; bus.lsg_data3 = G3;
    bus.lse_data  = E;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 128'({bus.lse_ready, bus.lsg_ready, bus.alu_ready}), 128'(3'b000));
    chk("reset enables", 128'({bus.reg_wr_en, bus.el_wr_en}), 128'(2'b00));
    chk("reset wr_mask", 128'(bus.wr_mask), 128'(32'h0));
    chk("reset err", 128'({bus.err, bus.err_src}), 128'(3'b000));
    chk("reset lmul/sew", 128'({bus.lmul, bus.sew}), 128'(6'd0));
    chk("reset data", bus.reg_wr_data, Z);
    chk("reset rr", 128'(dut.rr), 128'(2'd0));
    rst = 1'b0;

    foreach (vq[i]) apply(vq[i], i);

    // stall held three cycles: no grants, rr parked at 1
    idle_inputs();
    bus.stall = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd2;  bus.alu_lmul = 3'd1;
    bus.lsg_valid = 1'b1; bus.lsg_addr = 5'd12; bus.lsg_lmul = 3'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d ready", c), 128'({bus.lse_ready, bus.lsg_ready, bus.alu_ready}), 128'(3'b000));
      @(posedge clk); #1;
      chk($sformatf("stall%0d enables", c), 128'({bus.reg_wr_en, bus.el_wr_en}), 128'(2'b00));
      chk($sformatf("stall%0d rr", c), 128'(dut.rr), 128'(2'd1));
    end
    bus.stall = 1'b0;
    #1;
    chk("unstall ready", 128'({bus.lse_ready, bus.lsg_ready, bus.alu_ready}), 128'(3'b010));
    @(posedge clk); #1;
    bus.stall = 1'b1;
    #1;
    chk("unstall reg_wr_en", 128'(bus.reg_wr_en), 128'(1'b1));
    chk("unstall reg_wr_addr", 128'(bus.reg_wr_addr), 128'(5'd12));
    chk("unstall wr_mask", 128'(bus.wr_mask), 128'(32'h0000_F000));
    chk("unstall data", bus.reg_wr_data_4, G3);
    chk("restall ready", 128'({bus.lse_ready, bus.lsg_ready, bus.alu_ready}), 128'(3'b000));
    @(posedge clk); #1;
    chk("restall reg_wr_en", 128'(bus.reg_wr_en), 128'(1'b0));

    // load-group request presented while rst is high
    idle_inputs();
    bus.lsg_valid = 1'b1; bus.lsg_addr = 5'd16; bus.lsg_lmul = 3'd0;
    rst = 1'b1;
    #1;
    chk("rst lsg_ready", 128'(bus.lsg_ready), 128'(1'b0));
    @(posedge clk); #1;
    chk("rst enables", 128'({bus.reg_wr_en, bus.el_wr_en}), 128'(2'b00));
    chk("rst reg_wr_addr", 128'(bus.reg_wr_addr), 128'(5'd0));
    chk("rst lmul", 128'(bus.lmul), 128'(3'd0));
    chk("rst wr_mask", 128'(bus.wr_mask), 128'(32'h0));
    chk("rst err", 128'(bus.err), 128'(1'b0));
    chk("rst data", bus.reg_wr_data, Z);
    chk("rst rr", 128'(dut.rr), 128'(2'd0));
    rst = 1'b0;

    // all three valid from reset: grants rotate 0,1,2,0,1,2
    idle_inputs();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_lmul = 3'd0;
    bus.lsg_valid = 1'b1; bus.lsg_addr = 5'd8; bus.lsg_lmul = 3'd1;
    bus.lse_valid = 1'b1; bus.lse_reg = 5'd3; bus.lse_idx = 5'd5; bus.lse_sew = 3'd1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr%0d grant", c), 128'({bus.lse_ready, bus.lsg_ready, bus.alu_ready}),
          128'(3'b001 << (c % 3)));
      @(posedge clk); #1;
      chk($sformatf("rr%0d enables", c), 128'({bus.reg_wr_en, bus.el_wr_en}),
          128'(((c % 3) == 2) ? 2'b01 : 2'b10));
    end
    idle_inputs();
    @(posedge clk); #1;
    chk("final idle enables", 128'({bus.reg_wr_en, bus.el_wr_en}), 128'(2'b00));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/v_rf_wr_sched.md
# v_rf_wr_sched

Write-port scheduler for the vector register file. Three producers compete for the single register-file write interface each cycle: the vector ALU writeback (register-group writes), the load unit (register-group writes) and the load unit's element path (single-element writes). The scheduler arbitrates round-robin, checks each request for legality, drives the register file's write strobes, address, data, `lmul` and `sew` from a registered output stage, and publishes a bitmap of the registers being written.

## Interface
- `NREG`, 32, number of vector registers (must be 32; used for the bitmap width and the bounds check)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  pipeline hold; while high no request is granted
- `alu_valid`, `alu_ready`  in/out  1  ALU group-write handshake
- `alu_addr`  in  5  base register; `alu_lmul`  in  3  LMUL code; `alu_data0..3`  in  128 each
- `lsg_valid`, `lsg_ready`, `lsg_addr`, `lsg_lmul`, `lsg_data0..3`: load-group requester, same widths as ALU
- `lse_valid`, `lse_ready`  in/out  1  load-element handshake
- `lse_reg`  in  5  target register; `lse_idx`  in  5  element index; `lse_sew`  in  3  SEW code; `lse_data`  in  128  lane-aligned data
- `reg_wr_en`  out  1; `reg_wr_addr`  out  5; `reg_wr_data`, `_2`, `_3`, `_4`  out  128 each
- `el_wr_en`  out  1; `el_reg_wr_addr`  out  5; `el_wr_addr`  out  5; `el_wr_data`  out  128
- `lmul`  out  3; `sew`  out  3  (drive the register file)
- `wr_mask`  out  32  one bit per register written by the current output strobe
- `err`  out  1  one-cycle pulse: the accepted request was illegal and was dropped
- `err_src`  out  2  source of the dropped request: 0 ALU, 1 load-group, 2 load-element

## Operation
- Requester indices: 0 ALU, 1 load-group, 2 load-element. A 2-bit round-robin pointer `rr` names the highest-priority requester. Reset value of `rr` is 0.
- Grant: when `stall` is 0, grant the first valid requester scanning rr, rr+1, rr+2 (mod 3). Assert the winner's `*_ready` combinationally in the same cycle. All other readies stay 0. With `stall` = 1 or `rst` = 1, every ready is 0.
- On a grant, `rr` becomes (winner + 1) mod 3. With no grant, `rr` holds.
- LMUL codes: 000 = 1 register, 001 = 2, 010 = 4. Any other code is illegal.
- A group request is legal when the LMUL code is legal, the base address is aligned (even for LMUL 2, multiple of 4 for LMUL 4), and base + n - 1 ≤ 31.
- SEW codes: 000 = 8-bit, 001 = 16-bit, 010 = 32-bit. Any other code is illegal.
- An element request is legal when the SEW code is legal and `lse_idx` is below 16, 8 and 4 for SEW 8, 16 and 32 respectively.
- Legal group request: the next cycle has `reg_wr_en` = 1, `reg_wr_addr` = base, data0..3 on `reg_wr_data`.._4, `lmul` = the request code, `sew` = the previous `sew`, and `wr_mask` = n consecutive bits starting at base. Data words beyond n are still driven; the register file ignores them.
- Legal element request: the next cycle has `el_wr_en` = 1, `el_reg_wr_addr` = `lse_reg`, `el_wr_addr` = `lse_idx`, `el_wr_data` = `lse_data`, `sew` = `lse_sew`, `lmul` = the previous `lmul`, and `wr_mask` = 1 << `lse_reg`.
- Illegal request: the handshake completes (the request is consumed). The next cycle has both write enables at 0, `wr_mask` = 0, `err` = 1 and `err_src` = the source.
- `reg_wr_en` and `el_wr_en` are never high in the same cycle.

## Timing
- Latency is 1 cycle: a request accepted in cycle N (valid & ready at edge N) produces its strobes, `wr_mask` and `err` in cycle N+1. The register file captures the write at the end of N+1.
- Throughput is one request per cycle. Back-to-back grants to different requesters are allowed.
- Every output stage signal is a flop. Reset values: all enables 0, all addresses 0, all data 0, `lmul` = 000, `sew` = 000, `wr_mask` = 0, `err` = 0, `err_src` = 0, `rr` = 0.
- With no grant in cycle N, cycle N+1 has both enables 0, `wr_mask` = 0 and `err` = 0. Addresses, data, `lmul` and `sew` hold their previous values.
- `rst` asserted mid-stream clears the output stage at that edge. A request accepted in the same cycle as `rst` is discarded with no strobe and no `err`.
- `stall` rising while a write is in the output stage does not cancel that write; it only blocks new grants.
- A requester must hold `valid` and its payload stable until ready. The scheduler samples the payload only in the grant cycle.

## Test plan
- Reset, then ALU request with addr 4, lmul 010, data A..D → `alu_ready` = 1 in the same cycle; next cycle `reg_wr_en` = 1, `reg_wr_addr` = 4, `lmul` = 010, `wr_mask` = 0x000000F0; `rr` = 1.
- All three requesters valid continuously for 6 cycles from reset → grant order 0,1,2,0,1,2; each grant's strobe appears exactly one cycle later; enables are never both high.
- Element request with reg 3, idx 5, sew 001, data X → `el_wr_en` = 1, `el_reg_wr_addr` = 3, `el_wr_addr` = 5, `sew` = 001, `wr_mask` = 0x8. Then idx 8 with sew 001 → `err` = 1, `err_src` = 2, no enable.
- Illegal group requests: addr 30 with lmul 010, addr 5 with lmul 001, and lmul 011 → each is consumed, gives `err` = 1 with the correct `err_src`, and `wr_mask` = 0.
- `stall` high for 3 cycles with ALU and load-group valid → all readies 0 and no strobes; after `stall` falls the grant goes to the requester named by the held `rr`.
- `rst` pulsed in the same cycle as a load-group acceptance → next cycle all outputs are at reset values, `err` = 0, `rr` = 0.
